// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: latches a 16-bit word and shifts it out on sclk/sdata,
// one bit per DIV clocks, with a start/ready handshake upstream and a one-cycle done pulse.
module serial_word_tx #(
    parameter int unsigned DIV       = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [3:0]  bit_sel,
    output logic        sclk,
    output logic        sdata
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] HALF_DIV  = DW'(DIV / 2);
    localparam logic [DW-1:0] LAST_DIV  = DW'(DIV - 1);
    localparam logic [3:0]    FIRST_SEL = MSB_FIRST ? 4'd15 : 4'd0;
    localparam logic [3:0]    LAST_SEL  = MSB_FIRST ? 4'd0 : 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     word_q, word_d;
    logic [3:0]      sel_q, sel_d;
    logic [DW-1:0]   div_q, div_d;

    logic            ready_q, busy_q, done_q, sclk_q, sdata_q;
    logic            ready_d, busy_d, done_d, sclk_d, sdata_d;
    logic            bit_mux;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sel_d   = sel_q;
        div_d   = div_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    word_d  = data_in;
                    sel_d   = FIRST_SEL;
                    div_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (div_q == LAST_DIV) begin
                    div_d = '0;
                    if (sel_q == LAST_SEL) begin
                        state_d = StDone;
                    end else begin
                        sel_d = MSB_FIRST ? (sel_q - 4'd1) : (sel_q + 4'd1);
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // 16:1 bit-select stage driven by the next-cycle index so sdata is registered yet aligned.
    assign bit_mux = word_d[sel_d];

    always_comb begin
        ready_d = (state_d == StIdle);
        busy_d  = (state_d == StShift);
        done_d  = (state_d == StDone);
        sclk_d  = (state_d == StShift) && (div_d >= HALF_DIV);
        sdata_d = (state_d == StShift) && bit_mux;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            word_q  <= '0;
            sel_q   <= '0;
            div_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
            div_q   <= div_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bit_sel = sel_q;
    assign sclk    = sclk_q;
    assign sdata   = sdata_q;

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter: latches a 16-bit word, then uses a 4-bit bit-index counter as the select into a 16:1 bit-select stage to emit one bit at a time.
- Drives a clocked serial output (sclk/sdata) for off-chip peripherals, e.g. display/LED shift registers.
- Sits between processor memory-mapped I/O (upstream, start/ready handshake) and the external serial pins (downstream).

Parameters:
- DIV, 4, clock cycles per serial bit; even, >= 2; sclk low for first DIV/2 cycles of each bit, high for last DIV/2.
- MSB_FIRST, 1, 1 = bit 15 sent first (index counts 15→0); 0 = bit 0 first (index counts 0→15).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request to send data_in; sampled only in IDLE.
- data_in  input  16  word to transmit; captured on accepted start.
- ready  output  1  1 in IDLE only; start accepted when ready & start.
- busy  output  1  1 in SHIFT.
- done  output  1  single-cycle pulse after last bit completes.
- bit_sel  output  4  current bit index (select of the 16:1 bit stage); debug/observe.
- sclk  output  1  serial clock, registered.
- sdata  output  1  serial data, registered; stable for the whole bit period.

Behaviour:
- Reset (reset=0, async): state=IDLE, shift word=0, bit_sel=0, div counter=0, ready=1, busy=0, done=0, sclk=0, sdata=0. Takes effect immediately, including mid-transfer; the partial word is abandoned with no done pulse. After release, the first rising edge finds the block in IDLE.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, sclk=0, sdata=0.
  - On edge with start=1: latch data_in; bit_sel=15 if MSB_FIRST else 0; div counter=0; go to SHIFT.
  - data_in changes after acceptance have no effect.
- SHIFT:
  - sdata = latched_word[bit_sel], via the 16:1 selector.
  - sclk = 1 when div counter >= DIV/2, else 0.
  - The div counter increments each cycle. At DIV-1 it wraps to 0 and bit_sel steps by -1 (MSB_FIRST) or +1.
  - After the last bit's final cycle (bit_sel 0 for MSB_FIRST, 15 otherwise), go to DONE.
  - start is ignored while busy.
- DONE: exactly one cycle. done=1, ready=0, busy=0, sclk=0, sdata=0. Then IDLE. start asserted during DONE is ignored.
- Timing, start accepted on edge E:
  - Bit k (transmission order, k=0..15) occupies cycles E+1+k*DIV through E+(k+1)*DIV.
  - done is high in cycle E+16*DIV+1; ready returns in cycle E+16*DIV+2.
  - Back-to-back throughput: one word per 16*DIV+2 cycles.
- Widths: div counter sized ceil(log2(DIV)); bit_sel 4-bit with modulo-16 wrap never used (terminates at end value).
- Outputs are all registered; no combinational path from start/data_in to any output.

Test Plan:
- Reset defaults: hold reset=0, toggle clock → ready=1, busy=0, done=0, sclk=0, sdata=0, bit_sel=0.
- MSB-first word (DIV=4): start with data_in=16'hA5C3, sample sdata at each sclk rise → bits 1010_0101_1100_0011. Also check: 16 sclk rising edges; done high exactly at cycle E+65, one cycle only.
- LSB-first word (MSB_FIRST=0, DIV=4): data_in=16'h0001 → sdata=1 only during first bit (cycles E+1..E+4), then 0 for the remaining 15 bits; bit_sel counts 0→15.
- Busy protection: pulse start with data_in=16'hFFFF during SHIFT of 16'h0000 and during DONE → stream stays all zeros; no second transfer starts.
- Mid-transfer reset: assert reset=0 during bit 7 → outputs return to reset values asynchronously (same cycle, before next edge); no done pulse. A new start with 16'h8001 then transmits correctly from bit 15.
- Back-to-back: hold start=1 continuously with data_in=16'h1234 → successive transfers begin every 66 cycles (DIV=4). The second stream equals the first, with sclk low and ready high for exactly one cycle between them.
